rgb_sequencer: RTL and testbench

Phase sequencer for the RGB light controller. While the start control `sc` is high, it cycles red, then green, then blue, then back to red. Each phase lasts a programmable number of prescaled ticks and drives only its own channel through an 8-bit PWM at a programmable duty. It sits between the breadboard start switch and the clock source and the three LED drivers, and turns the raw clock into a timed, synchronous colour schedule.

---
 rtl/rgb_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 35 +++
 rtl/rgb_sequencer.sv | 131 +++++++++++++
 tb/tb_rgb_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB phase sequencer.
package rgb_pkg;

    typedef enum logic [1:0] {
        PhIdle  = 2'd0,
        PhRed   = 2'd1,
        PhGreen = 2'd2,
        PhBlue  = 2'd3
    } phase_e;

    localparam int unsigned LEN_RST  = 1;
    localparam logic [7:0]  DUTY_RST = 8'h80;

    // cfg_sel targets line up with the phase encodings of their channel
    localparam logic [1:0] CfgNone  = 2'd0;
    localparam logic [1:0] CfgRed   = 2'd1;
    localparam logic [1:0] CfgGreen = 2'd2;
    localparam logic [1:0] CfgBlue  = 2'd3;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by PRESCALE; tick is high on the last cycle of each period.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = $clog2(PRESCALE);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CntW'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rgb_sequencer.sv
// Red/green/blue phase sequencer with per-phase tick length and PWM duty.
module rgb_sequencer
    import rgb_pkg::*;
#(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned DUTY_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sc,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic              busy,
    output logic [1:0]        phase,
    output logic              phase_done,
    output logic              r_out,
    output logic              g_out,
    output logic              b_out
);

    phase_e            state_q, state_d;
    logic [LEN_W-1:0]  sh_len_q  [3];
    logic [DUTY_W-1:0] sh_duty_q [3];
    logic [LEN_W-1:0]  act_len_q;
    logic [DUTY_W-1:0] act_duty_q;
    logic [LEN_W-1:0]  tick_cnt_q;
    logic [DUTY_W-1:0] pwm_cnt_q;
    logic [LEN_W-1:0]  ld_len;
    logic [DUTY_W-1:0] ld_duty;
    logic              tick, expire, phase_chg, pwm_on;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (phase_chg),
        .en   (busy),
        .tick (tick)
    );

    assign busy   = (state_q != PhIdle);
    // A zero-length phase expires in its first cycle
    assign expire = busy && ((act_len_q == '0) ||
                             (tick && (tick_cnt_q == act_len_q - LEN_W'(1))));

    always_comb begin
        state_d = state_q;
        if (!sc) begin
            state_d = PhIdle;
        end else begin
            unique case (state_q)
                PhIdle:  state_d = PhRed;
                PhRed:   if (expire) state_d = PhGreen;
                PhGreen: if (expire) state_d = PhBlue;
                PhBlue:  if (expire) state_d = PhRed;
                default: state_d = PhIdle;
            endcase
        end
    end

    assign phase_chg = (state_d != state_q);

    // Values latched on entry; a write landing on the entry edge bypasses the shadow
    always_comb begin
        ld_len  = sh_len_q[0];
        ld_duty = sh_duty_q[0];
        for (int i = 0; i < 3; i++) begin
            if (state_d == phase_e'(2'(i + 1))) begin
                ld_len  = sh_len_q[i];
                ld_duty = sh_duty_q[i];
            end
        end
        if (cfg_we && (cfg_sel == 2'(state_d))) begin
            ld_len  = cfg_len;
            ld_duty = cfg_duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sh_len_q[i]  <= LEN_W'(LEN_RST);
                sh_duty_q[i] <= DUTY_W'(DUTY_RST);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cfg_we && (cfg_sel == 2'(i + 1))) begin
                    sh_len_q[i]  <= cfg_len;
                    sh_duty_q[i] <= cfg_duty;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PhIdle;
            act_len_q  <= LEN_W'(LEN_RST);
            act_duty_q <= DUTY_W'(DUTY_RST);
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (phase_chg) begin
                tick_cnt_q <= '0;
                pwm_cnt_q  <= '0;
                if (state_d != PhIdle) begin
                    act_len_q  <= ld_len;
                    act_duty_q <= ld_duty;
                end
            end else if (busy) begin
                pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
                if (tick) begin
                    tick_cnt_q <= tick_cnt_q + LEN_W'(1);
                end
            end
        end
    end

    assign pwm_on     = busy && (act_len_q != '0) && (pwm_cnt_q < act_duty_q);
    assign phase      = 2'(state_q);
    assign phase_done = expire;
    assign r_out      = pwm_on && (state_q == PhRed);
    assign g_out      = pwm_on && (state_q == PhGreen);
    assign b_out      = pwm_on && (state_q == PhBlue);

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer against a clock-count reference model.
module tb_rgb_sequencer;

    localparam int unsigned P = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sc = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic [15:0] cfg_len = '0;
    logic [7:0] cfg_duty = '0;
    logic       busy, phase_done, r_out, g_out, b_out;
    logic [1:0] phase;

    rgb_sequencer #(
        .PRESCALE(P),
        .LEN_W   (16),
        .DUTY_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sc        (sc),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_len   (cfg_len),
        .cfg_duty  (cfg_duty),
        .busy      (busy),
        .phase     (phase),
        .phase_done(phase_done),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic [1:0] phase;
        logic       done;
        logic       r;
        logic       g;
        logic       b;
    } obs_t;

    obs_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: phase number, clocks elapsed in it, and latched config
    int m_phase, m_el, m_len, m_duty;
    int sh_len [1:3];
    int sh_duty[1:3];

    function automatic void m_reset();
        m_phase = 0;
        m_el    = 0;
        m_len   = 1;
        m_duty  = 128;
        for (int i = 1; i <= 3; i++) begin
            sh_len[i]  = 1;
            sh_duty[i] = 128;
        end
    endfunction

    function automatic bit m_expire();
        return (m_phase != 0) && ((m_len == 0) || (m_el == m_len * P - 1));
    endfunction

    function automatic obs_t m_obs();
        obs_t o;
        bit   on;
        on      = (m_phase != 0) && (m_len != 0) && ((m_el % 256) < m_duty);
        o.busy  = (m_phase != 0);
        o.phase = 2'(m_phase);
        o.done  = m_expire();
        o.r     = on && (m_phase == 1);
        o.g     = on && (m_phase == 2);
        o.b     = on && (m_phase == 3);
        return o;
    endfunction

    task automatic step(input bit s, input bit we, input int sel, input int len, input int duty);
        int nxt;
        bit ex;
        @(negedge clk);
        rst_n    = 1'b1;
        sc       = s;
        cfg_we   = we;
        cfg_sel  = 2'(sel);
        cfg_len  = 16'(len);
        cfg_duty = 8'(duty);
        ex = m_expire();
        if (we && sel != 0) begin
            sh_len[sel]  = len;
            sh_duty[sel] = duty;
        end
        if (!s)                nxt = 0;
        else if (m_phase == 0) nxt = 1;
        else if (ex)           nxt = (m_phase == 3) ? 1 : m_phase + 1;
        else                   nxt = m_phase;
        if (nxt != m_phase && nxt != 0) begin
            m_len  = sh_len[nxt];
            m_duty = sh_duty[nxt];
            m_el   = 0;
        end else begin
            m_el++;
        end
        m_phase = nxt;
        q.push_back(m_obs());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic wr(input int sel, input int len, input int duty);
        step(1'b0, 1'b1, sel, len, duty);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n  = 1'b0;
        sc     = 1'b1;
        cfg_we = 1'b0;
        #1;
        total++;
        if ({busy, phase, phase_done, r_out, g_out, b_out} !== 7'd0) begin
            bad++;
            $display("FAIL async_reset: got %b want 0000000",
                     {busy, phase, phase_done, r_out, g_out, b_out});
        end
        m_reset();
        q.push_back(m_obs());
    endtask

    // Monitor: compare every registered observation just after the clock edge
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{busy: busy, phase: phase, done: phase_done, r: r_out, g: g_out, b: b_out};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL cycle %0d busy/phase/done/r/g/b: got %b want %b", cyc, a, e);
                end
            end
        end
    end

    initial begin
        bit found;
        m_reset();
        // Reset defaults, then reset again mid-run and restart with sc held high
        repeat (3) reset_cycle();
        run(20);
        repeat (2) reset_cycle();
        run(14);

        // Programmed lengths and duty extremes
        wr(1, 3, 0);
        wr(2, 2, 255);
        wr(3, 1, 128);
        run(30);

        // Zero-length green phase
        wr(2, 0, 200);
        run(12);

        // Stop during green, then restart at red
        repeat (2) reset_cycle();
        run(6);
        repeat (3) step(1'b0, 1'b0, 0, 0, 0);
        run(6);

        // Duty rewritten while red is active takes effect on the next red entry
        wr(1, 64, 128);
        run(10);
        step(1'b1, 1'b1, 1, 64, 16);
        run(300);

        // Stop on the exact expiry cycle returns to idle
        wr(1, 2, 100);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_phase != 0 && m_expire()) begin
                step(1'b0, 1'b0, 0, 0, 0);
                found = 1'b1;
            end else begin
                run(1);
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL stop_on_expiry: got no expiry cycle want one within 40 clocks");
        end
        run(1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r, d;
            r = int'($urandom_range(0, 199));
            d = ($urandom_range(0, 3) == 0) ? 0 :
                ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            if (r == 0) begin
                reset_cycle();
            end else begin
                step(r > 12, $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), d);
            end
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
